// File: rtl/pipeline_hazard_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM encoding, stage indices, hazard cause codes.
package pipeline_hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    localparam int NUM_STG    = 4;
    localparam int STG_IF_ID  = 0;
    localparam int STG_ID_EX  = 1;
    localparam int STG_EX_MEM = 2;
    localparam int STG_MEM_WB = 3;

    // Which rule currently owns the stall/flush outputs, highest priority first.
    typedef enum logic [2:0] {
        CAUSE_NONE       = 3'd0,
        CAUSE_DMEM_WAIT  = 3'd1,
        CAUSE_REDIRECT   = 3'd2,
        CAUSE_LOAD_USE   = 3'd3,
        CAUSE_FETCH_HOLD = 3'd4
    } cause_e;

    function automatic logic src_hits_rd(input logic uses, input logic [4:0] src,
                                         input logic [4:0] rd);
        return uses && (rd != 5'd0) && (src == rd);
    endfunction

endpackage

// File: rtl/pipeline_occ_tracker.sv
// Per-stage valid bits for IF/ID..MEM/WB, advanced by the same stall/flush vector that drives the stage registers.
module pipeline_occ_tracker
    import pipeline_hazard_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_valid,
    input  logic [NUM_STG-1:0] stall,
    input  logic [NUM_STG-1:0] flush,
    output logic [NUM_STG-1:0] occ,
    output logic               drained
);

    logic [NUM_STG-1:0] upstream;
    logic [NUM_STG-1:0] occ_next;

    assign upstream = {occ[NUM_STG-2:0], fetch_valid};

    always_comb begin
        occ_next = '0;
        for (int i = 0; i < NUM_STG; i++) begin
            if (flush[i])
                occ_next[i] = 1'b0;
            else if (stall[i])
                occ_next[i] = occ[i];
            else
                occ_next[i] = upstream[i];
        end
    end

    // Looks at the next value so the FSM can retire on the same edge the last stage empties.
    assign drained = (occ_next == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            occ <= '0;
        else
            occ <= occ_next;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with debug halt/drain and dmem timeout detection.
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
    import pipeline_hazard_pkg::*;
#(
    parameter int unsigned DMEM_TIMEOUT = 255,
    parameter int unsigned CNT_W        = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd_addr,
    input  logic        mem_redirect,
    input  logic [31:0] mem_redirect_target,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    input  logic        imem_ready,
    input  logic        halt_req,
    input  logic        resume_req,
    output logic        pc_stall,
    output logic        pc_redirect_valid,
    output logic [31:0] pc_redirect_target,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_stall,
    output logic        id_ex_flush,
    output logic        ex_mem_stall,
    output logic        ex_mem_flush,
    output logic        mem_wb_stall,
    output logic        mem_wb_flush,
    output logic        halted,
    output logic        bus_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_stall_cycles,
    output logic [CNT_W-1:0] perf_flush_events
`endif
);

    // state  | meaning
    // RUN    | normal fetch and issue
    // DRAIN  | fetch held, waiting for all stage registers to empty
    // HALTED | pipeline empty, parked until resume_req

    if (DMEM_TIMEOUT < 1 || DMEM_TIMEOUT > 65535 || CNT_W < 1) begin : g_param_err
        $error("pipeline_hazard_ctrl: DMEM_TIMEOUT must be 1..65535 and CNT_W >= 1");
    end

    localparam logic [15:0] TO_LIM = 16'(DMEM_TIMEOUT);

    state_e             state;
    cause_e             cause;
    logic               dmem_wait;
    logic               load_use;
    logic               fetch_hold;
    logic               drained;
    logic [NUM_STG-1:0] stg_stall;
    logic [NUM_STG-1:0] stg_flush;
    logic [NUM_STG-1:0] occ;
    logic [15:0]        wait_cnt;

    assign dmem_wait  = dmem_req && !dmem_ready;
    assign load_use   = ex_mem_read &&
                        (src_hits_rd(id_uses_rs1, id_rs1_addr, ex_rd_addr) ||
                         src_hits_rd(id_uses_rs2, id_rs2_addr, ex_rd_addr));
    assign fetch_hold = !imem_ready || (state != ST_RUN);

    always_comb begin
        cause             = CAUSE_NONE;
        pc_stall          = 1'b0;
        pc_redirect_valid = 1'b0;
        if_id_stall       = 1'b0;
        if_id_flush       = 1'b0;
        id_ex_stall       = 1'b0;
        id_ex_flush       = 1'b0;
        ex_mem_stall      = 1'b0;
        ex_mem_flush      = 1'b0;
        mem_wb_stall      = 1'b0;
        mem_wb_flush      = 1'b0;
        if (dmem_wait) begin
            cause        = CAUSE_DMEM_WAIT;
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (mem_redirect) begin
            cause             = CAUSE_REDIRECT;
            pc_redirect_valid = 1'b1;
            if_id_flush       = 1'b1;
            id_ex_flush       = 1'b1;
            ex_mem_flush      = 1'b1;
        end else if (load_use) begin
            cause       = CAUSE_LOAD_USE;
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end else if (fetch_hold) begin
            cause       = CAUSE_FETCH_HOLD;
            pc_stall    = 1'b1;
            if_id_flush = 1'b1;
        end
    end

    assign pc_redirect_target = mem_redirect_target;

    assign stg_stall[STG_IF_ID]  = if_id_stall;
    assign stg_stall[STG_ID_EX]  = id_ex_stall;
    assign stg_stall[STG_EX_MEM] = ex_mem_stall;
    assign stg_stall[STG_MEM_WB] = mem_wb_stall;
    assign stg_flush[STG_IF_ID]  = if_id_flush;
    assign stg_flush[STG_ID_EX]  = id_ex_flush;
    assign stg_flush[STG_EX_MEM] = ex_mem_flush;
    assign stg_flush[STG_MEM_WB] = mem_wb_flush;

    pipeline_occ_tracker u_occ (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_valid (state == ST_RUN && imem_ready),
        .stall       (stg_stall),
        .flush       (stg_flush),
        .occ         (occ),
        .drained     (drained)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_RUN;
            halted <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (halt_req)
                        state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (drained) begin
                        state  <= ST_HALTED;
                        halted <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (resume_req) begin
                        state  <= ST_RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    // Counter saturates at the limit; bus_err is set on the edge the count reaches it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 16'd0;
            bus_err  <= 1'b0;
        end else if (dmem_wait) begin
            if (wait_cnt != TO_LIM)
                wait_cnt <= wait_cnt + 16'd1;
            if (wait_cnt == TO_LIM - 16'd1)
                bus_err <= 1'b1;
        end else begin
            wait_cnt <= 16'd0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cycles <= '0;
            perf_flush_events <= '0;
        end else begin
            if (pc_stall)
                perf_stall_cycles <= perf_stall_cycles + CNT_W'(1);
            if (|stg_flush)
                perf_flush_events <= perf_flush_events + CNT_W'(1);
        end
    end
`else
    // Perf counters compiled out; the remaining behaviour is unchanged.
`endif

    a_no_stall_and_flush : assert property (@(posedge clk) disable iff (!rst_n)
        ((stg_stall & stg_flush) == '0) && !(pc_stall && pc_redirect_valid));
    a_redirect_cause : assert property (@(posedge clk) disable iff (!rst_n)
        pc_redirect_valid |-> (cause == CAUSE_REDIRECT));

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: hazard priorities, occupancy, halt/drain, dmem timeout, async reset.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic        id_uses_rs1, id_uses_rs2, ex_mem_read;
    logic        mem_redirect;
    logic [31:0] mem_redirect_target;
    logic        dmem_req, dmem_ready, imem_ready, halt_req, resume_req;
    logic        pc_stall, pc_redirect_valid;
    logic [31:0] pc_redirect_target;
    logic        if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic        ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush;
    logic        halted, bus_err;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cycles, perf_flush_events;
`endif

    logic [9:0] outs;
    int tests = 0;
    int fails = 0;

    // Bit order: pc_stall, redirect_valid, if_id s/f, id_ex s/f, ex_mem s/f, mem_wb s/f
    localparam logic [9:0] O_NONE  = 10'b00_00_00_00_00;
    localparam logic [9:0] O_LU    = 10'b10_10_01_00_00;
    localparam logic [9:0] O_DWAIT = 10'b10_10_10_10_01;
    localparam logic [9:0] O_REDIR = 10'b01_01_01_01_00;
    localparam logic [9:0] O_FHOLD = 10'b10_01_00_00_00;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.DMEM_TIMEOUT(4)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .id_rs1_addr         (id_rs1_addr),
        .id_rs2_addr         (id_rs2_addr),
        .id_uses_rs1         (id_uses_rs1),
        .id_uses_rs2         (id_uses_rs2),
        .ex_mem_read         (ex_mem_read),
        .ex_rd_addr          (ex_rd_addr),
        .mem_redirect        (mem_redirect),
        .mem_redirect_target (mem_redirect_target),
        .dmem_req            (dmem_req),
        .dmem_ready          (dmem_ready),
        .imem_ready          (imem_ready),
        .halt_req            (halt_req),
        .resume_req          (resume_req),
        .pc_stall            (pc_stall),
        .pc_redirect_valid   (pc_redirect_valid),
        .pc_redirect_target  (pc_redirect_target),
        .if_id_stall         (if_id_stall),
        .if_id_flush         (if_id_flush),
        .id_ex_stall         (id_ex_stall),
        .id_ex_flush         (id_ex_flush),
        .ex_mem_stall        (ex_mem_stall),
        .ex_mem_flush        (ex_mem_flush),
        .mem_wb_stall        (mem_wb_stall),
        .mem_wb_flush        (mem_wb_flush),
        .halted              (halted),
        .bus_err             (bus_err)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_stall_cycles   (perf_stall_cycles),
        .perf_flush_events   (perf_flush_events)
`endif
    );

    assign outs = {pc_stall, pc_redirect_valid, if_id_stall, if_id_flush, id_ex_stall,
                   id_ex_flush, ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] drain_occ [4];
        logic       drain_hlt [4];
        drain_occ = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
        drain_hlt = '{1'b0, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0;
        id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ex_rd_addr = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
        mem_redirect = 1'b0; mem_redirect_target = 32'h0;
        dmem_req = 1'b0; dmem_ready = 1'b1; imem_ready = 1'b1;
        halt_req = 1'b0; resume_req = 1'b0;

        #2;
        chk("rst_outs", 32'(outs), 32'(O_NONE));
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_occ", 32'(dut.occ), 32'h0);
        #10 rst_n = 1'b1;

        tick();
        chk("fill1_occ", 32'(dut.occ), 32'h1);
        tick(); tick(); tick();
        chk("fill4_occ", 32'(dut.occ), 32'hF);

        // T1 load-use on rs2
        ex_mem_read = 1'b1; ex_rd_addr = 5'd5; id_rs2_addr = 5'd5; id_uses_rs2 = 1'b1;
        #1 chk("t1_loaduse", 32'(outs), 32'(O_LU));
        tick();
        chk("t1_occ", 32'(dut.occ), 32'hD);
        ex_mem_read = 1'b0; id_uses_rs2 = 1'b0;
        #1 chk("t1_clear", 32'(outs), 32'(O_NONE));
        tick();
        chk("t1_occ2", 32'(dut.occ), 32'hB);

        ex_mem_read = 1'b1; ex_rd_addr = 5'd7; id_rs1_addr = 5'd7; id_uses_rs1 = 1'b1;
        #1 chk("t1_loaduse_rs1", 32'(outs), 32'(O_LU));
        id_uses_rs1 = 1'b0;
        #1 chk("t1_rs1_unused", 32'(outs), 32'(O_NONE));

        // T2 rd=0 never hazards; redirect beats load-use
        id_uses_rs2 = 1'b1; id_rs2_addr = 5'd0; ex_rd_addr = 5'd0;
        #1 chk("t2_rd0", 32'(outs), 32'(O_NONE));
        ex_rd_addr = 5'd5; id_rs2_addr = 5'd5;
        mem_redirect = 1'b1; mem_redirect_target = 32'h0000_0100;
        #1 chk("t2_redir", 32'(outs), 32'(O_REDIR));
        chk("t2_target", pc_redirect_target, 32'h0000_0100);
        tick();
        chk("t2_occ", 32'(dut.occ), 32'h0);
        ex_mem_read = 1'b0; id_uses_rs2 = 1'b0; mem_redirect = 1'b0;

        imem_ready = 1'b0;
        #1 chk("fetch_hold", 32'(outs), 32'(O_FHOLD));
        tick();
        chk("fetch_hold_occ", 32'(dut.occ), 32'h0);
        imem_ready = 1'b1;
        tick(); tick(); tick(); tick();
        chk("refill_occ", 32'(dut.occ), 32'hF);

        // T3 dmem wait overrides redirect
        dmem_req = 1'b1; dmem_ready = 1'b0; mem_redirect = 1'b1; mem_redirect_target = 32'h200;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t3_dwait", 32'(outs), 32'(O_DWAIT));
            tick();
        end
        chk("t3_occ", 32'(dut.occ), 32'h7);
        chk("t3_bus_err", 32'(bus_err), 32'd0);
        dmem_req = 1'b0; dmem_ready = 1'b1; mem_redirect = 1'b0;
        #1 chk("t3_release", 32'(outs), 32'(O_NONE));
        tick();
        chk("t3_occ2", 32'(dut.occ), 32'hF);

        // T4 timeout of 4 wait edges
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk($sformatf("t4_bus_err_%0d", i), 32'(bus_err), (i >= 4) ? 32'd1 : 32'd0);
        end
        chk("t4_still_stalled", 32'(outs), 32'(O_DWAIT));
        dmem_req = 1'b0; dmem_ready = 1'b1;
        tick();
        chk("t4_sticky", 32'(bus_err), 32'd1);
        chk("t4_occ", 32'(dut.occ), 32'hF);

        // T5 halt, drain, resume
        halt_req = 1'b1;
        #1 chk("t5_run_outs", 32'(outs), 32'(O_NONE));
        tick();
        halt_req = 1'b0;
        chk("t5_enter_occ", 32'(dut.occ), 32'hF);
        chk("t5_enter_halted", 32'(halted), 32'd0);
        chk("t5_drain_outs", 32'(outs), 32'(O_FHOLD));
        resume_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            resume_req = 1'b0;
            chk($sformatf("t5_drain_occ_%0d", i), 32'(dut.occ), 32'(drain_occ[i]));
            chk($sformatf("t5_drain_halted_%0d", i), 32'(halted), 32'(drain_hlt[i]));
        end
        chk("t5_halted_outs", 32'(outs), 32'(O_FHOLD));
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("t5_halt_ignored", 32'(halted), 32'd1);
        resume_req = 1'b1;
        tick();
        resume_req = 1'b0;
        chk("t5_resumed", 32'(halted), 32'd0);
        chk("t5_resumed_outs", 32'(outs), 32'(O_NONE));
        tick();
        chk("t5_fetch_occ", 32'(dut.occ), 32'h1);

        // T6 async reset mid-drain
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        tick();
        chk("t6_drain_occ", 32'(dut.occ), 32'h6);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_occ", 32'(dut.occ), 32'h0);
        chk("t6_halted", 32'(halted), 32'd0);
        chk("t6_bus_err", 32'(bus_err), 32'd0);
        chk("t6_run_outs", 32'(outs), 32'(O_NONE));
        #1 rst_n = 1'b1;

        // T6 async reset mid-wait
        tick(); tick();
        chk("t6_refill_occ", 32'(dut.occ), 32'h3);
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("t6_wait_err", 32'(bus_err), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_wait_bus_err", 32'(bus_err), 32'd0);
        chk("t6_wait_occ", 32'(dut.occ), 32'h0);
        chk("t6_wait_outs", 32'(outs), 32'(O_DWAIT));
        #1 rst_n = 1'b1;
        tick(); tick(); tick();
        chk("t6_cnt_cleared", 32'(bus_err), 32'd0);
        tick();
        chk("t6_cnt_recount", 32'(bus_err), 32'd1);
        dmem_req = 1'b0; dmem_ready = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
